// File: rtl/alu_operand_sequencer.sv
// Operand-holding and sequencing stage around the 8-bit add/subtract unit.
// Holds A and B, steers the adder through one EXEC cycle and captures its result and flags.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for start; ld_a may load the accumulator
// S_LOAD_B | B captured from bus_in
// S_EXEC   | adder enabled; result and flags written at closing edge
// S_DONE   | one-cycle completion pulse
module alu_operand_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] bus_in,
   input  logic             ld_a,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] res_in,
   input  logic             cout_in,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out,
   output logic             sub,
   output logic             out_en,
   output logic             carry_flag,
   output logic             zero_flag,
   output logic             ovf_flag,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD_B = 2'd1,
      S_EXEC   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             op_q;
   logic             a_msb;
   logic             b_msb;
   logic             r_msb;
   logic             ovf_nxt;

   assign a_msb = a_q[WIDTH-1];
   assign b_msb = b_q[WIDTH-1];
   assign r_msb = res_in[WIDTH-1];

   // Subtract overflows when the operand signs differ; add when they match.
   always_comb begin
      ovf_nxt = 1'b0;
      if (op_q)
         ovf_nxt = (a_msb != b_msb) && (r_msb != a_msb);
      else
         ovf_nxt = (a_msb == b_msb) && (r_msb != a_msb);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= 1'b0;
         carry_flag <= 1'b0;
         zero_flag  <= 1'b0;
         ovf_flag   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_q  <= op;
                  state <= S_LOAD_B;
                  busy  <= 1'b1;
               end else if (ld_a) begin
                  a_q <= bus_in;
               end
            end
            S_LOAD_B: begin
               b_q   <= bus_in;
               state <= S_EXEC;
            end
            S_EXEC: begin
               a_q        <= res_in;
               carry_flag <= cout_in;
               zero_flag  <= (res_in == '0);
               ovf_flag   <= ovf_nxt;
               state      <= S_DONE;
               done       <= 1'b1;
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // The adder only drives the bus during EXEC.
   assign out_en = (state == S_EXEC);
   assign sub    = op_q;
   assign a_out  = a_q;
   assign b_out  = b_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a behavioural adder on res_in/cout_in.
// Inputs change 1ns after the rising edge; outputs are checked at that same point.
module tb_alu_operand_sequencer;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] bus_in;
   logic             ld_a;
   logic             start;
   logic             op;
   logic [WIDTH-1:0] res_in;
   logic             cout_in;
   logic [WIDTH-1:0] a_out;
   logic [WIDTH-1:0] b_out;
   logic             sub;
   logic             out_en;
   logic             carry_flag;
   logic             zero_flag;
   logic             ovf_flag;
   logic             busy;
   logic             done;

   int errors = 0;
   int checks = 0;

   alu_operand_sequencer #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus_in     (bus_in),
      .ld_a       (ld_a),
      .start      (start),
      .op         (op),
      .res_in     (res_in),
      .cout_in    (cout_in),
      .a_out      (a_out),
      .b_out      (b_out),
      .sub        (sub),
      .out_en     (out_en),
      .carry_flag (carry_flag),
      .zero_flag  (zero_flag),
      .ovf_flag   (ovf_flag),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Adder model: subtract is A + ~B + 1, carry out is the raw ninth bit.
   logic [WIDTH:0] sum_full;
   always_comb begin
      sum_full = '0;
      if (sub)
         sum_full = {1'b0, a_out} + {1'b0, ~b_out} + 9'd1;
      else
         sum_full = {1'b0, a_out} + {1'b0, b_out};
   end
   assign res_in  = sum_full[WIDTH-1:0];
   assign cout_in = sum_full[WIDTH];

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Load A, run one operation with B, check every phase and the final flags.
   task automatic run_op(input string tag, input logic [7:0] a_val, input logic [7:0] b_val,
                         input logic op_v, input logic [7:0] exp_a,
                         input logic exp_c, input logic exp_z, input logic exp_v);
      ld_a = 1'b1; bus_in = a_val;
      tick();
      ld_a = 1'b0;
      check_eq({tag, " a_load"}, 16'(a_out), 16'(a_val));
      start = 1'b1; op = op_v; bus_in = b_val;
      tick();
      start = 1'b0; op = 1'b0;
      check_eq({tag, " busy_ldb"}, 16'(busy), 16'd1);
      check_eq({tag, " oe_ldb"}, 16'(out_en), 16'd0);
      tick();
      bus_in = 8'h00;
      check_eq({tag, " b_exec"}, 16'(b_out), 16'(b_val));
      check_eq({tag, " oe_exec"}, 16'(out_en), 16'd1);
      check_eq({tag, " sub_exec"}, 16'(sub), 16'(op_v));
      check_eq({tag, " done_exec"}, 16'(done), 16'd0);
      tick();
      check_eq({tag, " done"}, 16'(done), 16'd1);
      check_eq({tag, " oe_done"}, 16'(out_en), 16'd0);
      check_eq({tag, " result"}, 16'(a_out), 16'(exp_a));
      check_eq({tag, " flags_cz_v"}, 16'({carry_flag, zero_flag, ovf_flag}),
               16'({exp_c, exp_z, exp_v}));
      tick();
      check_eq({tag, " done_clr"}, 16'(done), 16'd0);
      check_eq({tag, " busy_clr"}, 16'(busy), 16'd0);
   endtask

   initial begin
      int done_cnt;
      rst = 1'b1; bus_in = '0; ld_a = 1'b0; start = 1'b0; op = 1'b0;
      tick();
      rst = 1'b0;
      check_eq("rst a", 16'(a_out), 16'h00);
      check_eq("rst b", 16'(b_out), 16'h00);
      check_eq("rst ctl", 16'({busy, done, out_en, sub}), 16'h0);
      check_eq("rst flags", 16'({carry_flag, zero_flag, ovf_flag}), 16'h0);

      run_op("add",      8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);
      run_op("sub_zero", 8'h08, 8'h08, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
      run_op("add_ovf",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1);
      run_op("add_wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      run_op("sub_ovf",  8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b1);

      // Flags hold across ld_a.
      ld_a = 1'b1; bus_in = 8'h10;
      tick();
      ld_a = 1'b0;
      check_eq("hold flags", 16'({carry_flag, zero_flag, ovf_flag}), 16'b101);

      // Handshake robustness: start/ld_a pulses while busy are ignored.
      done_cnt = 0;
      start = 1'b1; op = 1'b0; bus_in = 8'h20;
      tick();                                   // LOAD_B
      start = 1'b1; ld_a = 1'b1;                // bus stays 0x20 for B
      tick();                                   // EXEC
      check_eq("rob b", 16'(b_out), 16'h20);
      check_eq("rob a_kept", 16'(a_out), 16'h10);
      bus_in = 8'hAA;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i == 0) begin
            start = 1'b0; ld_a = 1'b0; bus_in = 8'h00;
         end
         if (done) done_cnt++;
      end
      check_eq("rob result", 16'(a_out), 16'h30);
      check_eq("rob done_cnt", 16'(done_cnt), 16'd1);
      check_eq("rob idle", 16'(busy), 16'd0);

      // Priority: start beats ld_a in the same IDLE cycle.
      start = 1'b1; ld_a = 1'b1; op = 1'b0; bus_in = 8'h11;
      tick();
      start = 1'b0; ld_a = 1'b0;
      check_eq("prio a", 16'(a_out), 16'h30);
      check_eq("prio busy", 16'(busy), 16'd1);
      tick();
      bus_in = 8'h00;
      check_eq("prio b", 16'(b_out), 16'h11);
      tick();
      check_eq("prio result", 16'(a_out), 16'h41);
      tick();

      // Make the flags nonzero, then abort an operation in EXEC.
      run_op("pre_abort", 8'hFF, 8'h01, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0);
      ld_a = 1'b1; bus_in = 8'h05;
      tick();
      ld_a = 1'b0;
      start = 1'b1; op = 1'b0; bus_in = 8'h03;
      tick();
      start = 1'b0;
      tick();
      check_eq("abort oe", 16'(out_en), 16'd1);
      check_eq("abort res_in", 16'(res_in), 16'h08);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("abort a", 16'(a_out), 16'h00);
      check_eq("abort b", 16'(b_out), 16'h00);
      check_eq("abort ctl", 16'({busy, done, out_en, sub}), 16'h0);
      check_eq("abort flags", 16'({carry_flag, zero_flag, ovf_flag}), 16'h0);
      tick();
      check_eq("abort no_done", 16'({busy, done}), 16'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
